// File: rtl/voice_rom_scheduler.sv
// Polyphonic phase-accumulator scheduler sharing one registered sine ROM; sums enabled voices per frame.
// Latency: o_Sample_Valid NUM_VOICES+2 cycles after an accepted tick; no backpressure, ticks while busy are dropped and flagged.
module voice_rom_scheduler #(
    parameter int NUM_VOICES    = 4,
    parameter int ACC_WIDTH     = 24,
    parameter int ROM_ADDR_BITS = 8,
    parameter int SAMPLE_BITS   = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_Sample_Tick,
    input  logic                          i_Cfg_Wr,
    input  logic [$clog2(NUM_VOICES)-1:0] i_Cfg_Voice,
    input  logic [ACC_WIDTH-1:0]          i_Cfg_Inc,
    input  logic                          i_Cfg_En,
    output logic [ROM_ADDR_BITS-1:0]      o_Rom_Addr,
    input  logic [SAMPLE_BITS-1:0]        i_Rom_Data,
    output logic [SAMPLE_BITS-1:0]        o_Sample,
    output logic                          o_Sample_Valid,
    output logic                          o_Busy,
    output logic                          o_Overrun
);
    localparam int VB = $clog2(NUM_VOICES);
    localparam int SW = SAMPLE_BITS + VB;
    localparam logic [VB-1:0] LAST_V = VB'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [VB-1:0]            v_q, v_d;
    logic [ACC_WIDTH-1:0]     phase_q [NUM_VOICES];
    logic [ACC_WIDTH-1:0]     phase_d [NUM_VOICES];
    logic [ACC_WIDTH-1:0]     inc_q [NUM_VOICES];
    logic [ACC_WIDTH-1:0]     inc_d [NUM_VOICES];
    logic [ACC_WIDTH-1:0]     sh_inc_q [NUM_VOICES];
    logic [ACC_WIDTH-1:0]     sh_inc_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]    en_q, en_d, sh_en_q, sh_en_d, pend_q, pend_d;
    logic                     en_p_q, en_p_d;
    logic signed [SW-1:0]     acc_q, acc_d, acc_sum, rom_sext;
    logic [ROM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
    logic [SAMPLE_BITS-1:0]   sample_q, sample_d;
    logic                     valid_q, valid_d, overrun_q, overrun_d;

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        phase_d    = phase_q;
        inc_d      = inc_q;
        sh_inc_d   = sh_inc_q;
        en_d       = en_q;
        sh_en_d    = sh_en_q;
        pend_d     = pend_q;
        en_p_d     = 1'b0;
        acc_d      = acc_q;
        rom_addr_d = '0;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q | (i_Sample_Tick && state_q != S_IDLE);
        rom_sext   = {{VB{i_Rom_Data[SAMPLE_BITS-1]}}, i_Rom_Data};
        // en_p_q marks the cycle where the ROM returns an enabled voice's word
        acc_sum    = en_p_q ? acc_q + rom_sext : acc_q;

        case (state_q)
            S_IDLE: begin
                if (i_Sample_Tick) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (pend_q[i]) begin
                            if (!sh_en_q[i] || !en_q[i]) phase_d[i] = '0;
                            inc_d[i]  = sh_inc_q[i];
                            en_d[i]   = sh_en_q[i];
                            pend_d[i] = 1'b0;
                        end
                    end
                    acc_d      = '0;
                    v_d        = '0;
                    state_d    = S_RUN;
                    rom_addr_d = phase_d[0][ACC_WIDTH-1 -: ROM_ADDR_BITS];
                end
            end
            S_RUN: begin
                acc_d  = acc_sum;
                en_p_d = en_q[v_q];
                if (en_q[v_q]) phase_d[v_q] = phase_q[v_q] + inc_q[v_q];
                if (v_q == LAST_V) begin
                    state_d = S_DRAIN;
                end else begin
                    v_d        = v_q + 1'b1;
                    rom_addr_d = phase_q[v_d][ACC_WIDTH-1 -: ROM_ADDR_BITS];
                end
            end
            S_DRAIN: begin
                acc_d    = acc_sum;
                sample_d = SAMPLE_BITS'(acc_sum >>> VB);
                valid_d  = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // applied after the commit so a same-cycle write waits for the next frame
        if (i_Cfg_Wr) begin
            sh_inc_d[i_Cfg_Voice] = i_Cfg_Inc;
            sh_en_d[i_Cfg_Voice]  = i_Cfg_En;
            pend_d[i_Cfg_Voice]   = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            v_q        <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]  <= '0;
                inc_q[i]    <= '0;
                sh_inc_q[i] <= '0;
            end
            en_q       <= '0;
            sh_en_q    <= '0;
            pend_q     <= '0;
            en_p_q     <= 1'b0;
            acc_q      <= '0;
            rom_addr_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]  <= phase_d[i];
                inc_q[i]    <= inc_d[i];
                sh_inc_q[i] <= sh_inc_d[i];
            end
            en_q       <= en_d;
            sh_en_q    <= sh_en_d;
            pend_q     <= pend_d;
            en_p_q     <= en_p_d;
            acc_q      <= acc_d;
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_Rom_Addr     = rom_addr_q;
    assign o_Sample       = sample_q;
    assign o_Sample_Valid = valid_q;
    assign o_Busy         = (state_q != S_IDLE);
    assign o_Overrun      = overrun_q;
endmodule

// File: tb/tb_voice_rom_scheduler.sv
// Bench for voice_rom_scheduler: directed scenarios plus randomized frames checked against a frame-level model.
module tb_voice_rom_scheduler;
    localparam int N  = 4;
    localparam int AW = 24;
    localparam int RB = 8;
    localparam int SB = 16;
    localparam int VB = 2;

    logic          i_Clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Sample_Tick = 1'b0;
    logic          i_Cfg_Wr = 1'b0;
    logic [VB-1:0] i_Cfg_Voice = '0;
    logic [AW-1:0] i_Cfg_Inc = '0;
    logic          i_Cfg_En = 1'b0;
    logic [RB-1:0] o_Rom_Addr;
    logic [SB-1:0] i_Rom_Data = '0;
    logic [SB-1:0] o_Sample;
    logic          o_Sample_Valid;
    logic          o_Busy;
    logic          o_Overrun;

    voice_rom_scheduler #(.NUM_VOICES(N), .ACC_WIDTH(AW), .ROM_ADDR_BITS(RB), .SAMPLE_BITS(SB)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Sample_Tick(i_Sample_Tick), .i_Cfg_Wr(i_Cfg_Wr),
        .i_Cfg_Voice(i_Cfg_Voice), .i_Cfg_Inc(i_Cfg_Inc), .i_Cfg_En(i_Cfg_En),
        .o_Rom_Addr(o_Rom_Addr), .i_Rom_Data(i_Rom_Data), .o_Sample(o_Sample),
        .o_Sample_Valid(o_Sample_Valid), .o_Busy(o_Busy), .o_Overrun(o_Overrun)
    );

    always #5 i_Clk = ~i_Clk;

    // registered ROM, one cycle latency
    logic [SB-1:0] rom_tbl [256];
    always @(posedge i_Clk) i_Rom_Data <= rom_tbl[o_Rom_Addr];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // frame-level reference model
    logic [AW-1:0] m_phase [N];
    logic [AW-1:0] m_inc [N];
    logic [AW-1:0] m_sh_inc [N];
    bit            m_en [N];
    bit            m_sh_en [N];
    bit            m_pend [N];
    bit            m_overrun;

    function automatic void model_reset();
        for (int v = 0; v < N; v++) begin
            m_phase[v] = '0; m_inc[v] = '0; m_sh_inc[v] = '0;
            m_en[v] = 0; m_sh_en[v] = 0; m_pend[v] = 0;
        end
        m_overrun = 0;
    endfunction

    function automatic void model_write(input int v, input logic [AW-1:0] inc, input bit en);
        m_sh_inc[v] = inc; m_sh_en[v] = en; m_pend[v] = 1;
    endfunction

    function automatic void model_commit();
        for (int v = 0; v < N; v++) begin
            if (m_pend[v]) begin
                if (!m_sh_en[v] || !m_en[v]) m_phase[v] = '0;
                m_inc[v] = m_sh_inc[v];
                m_en[v]  = m_sh_en[v];
                m_pend[v] = 0;
            end
        end
    endfunction

    task automatic drive_cfg(input int v, input logic [AW-1:0] inc, input bit en);
        i_Cfg_Wr = 1'b1; i_Cfg_Voice = VB'(v); i_Cfg_Inc = inc; i_Cfg_En = en;
        model_write(v, inc, en);
    endtask

    task automatic cfg_write(input int v, input logic [AW-1:0] inc, input bit en);
        drive_cfg(v, inc, en);
        @(negedge i_Clk);
        i_Cfg_Wr = 1'b0;
    endtask

    // One frame: tick, optional config write at offset wr_k (0 = same cycle as tick), optional busy tick.
    task automatic frame(input bit extra_tick, input int wr_k, input int wr_v,
                         input logic [AW-1:0] wr_inc, input bit wr_en, output logic [SB-1:0] smp);
        logic [RB-1:0] exp_addr [N];
        logic [AW-1:0] ph;
        int sum, rv, exp_s;
        i_Sample_Tick = 1'b1;
        model_commit();
        if (wr_k == 0) drive_cfg(wr_v, wr_inc, wr_en);
        sum = 0;
        for (int v = 0; v < N; v++) begin
            ph = m_phase[v];
            exp_addr[v] = ph[AW-1 -: RB];
            if (m_en[v]) begin
                rv = $signed(rom_tbl[exp_addr[v]]);
                sum += rv;
                m_phase[v] = m_phase[v] + m_inc[v];
            end
        end
        exp_s = sum >>> VB;
        if (extra_tick) m_overrun = 1;
        smp = '0;
        @(posedge i_Clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge i_Clk);
            check_eq($sformatf("busy_k%0d", k), 32'(o_Busy), 32'(k <= N + 2));
            check_eq($sformatf("valid_k%0d", k), 32'(o_Sample_Valid), 32'(k == N + 2));
            if (k <= N) check_eq($sformatf("addr_v%0d", k - 1), 32'(o_Rom_Addr), 32'(exp_addr[k-1]));
            else        check_eq($sformatf("addr_idle_k%0d", k), 32'(o_Rom_Addr), 32'd0);
            if (k == N + 2) begin
                check_eq("sample", 32'(o_Sample), 32'(exp_s[SB-1:0]));
                smp = o_Sample;
            end
            if (k == 7) begin
                check_eq("sample_hold", 32'(o_Sample), 32'(exp_s[SB-1:0]));
                check_eq("overrun", 32'(o_Overrun), 32'(m_overrun));
            end
            i_Sample_Tick = extra_tick && (k == 2);
            if (wr_k == k) drive_cfg(wr_v, wr_inc, wr_en);
            else i_Cfg_Wr = 1'b0;
        end
        i_Sample_Tick = 1'b0;
        i_Cfg_Wr = 1'b0;
    endtask

    task automatic plain_frame(output logic [SB-1:0] smp);
        frame(0, -1, 0, '0, 0, smp);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"}, 32'(o_Rom_Addr), 32'd0);
        check_eq({tag, "_sample"}, 32'(o_Sample), 32'd0);
        check_eq({tag, "_valid"}, 32'(o_Sample_Valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(o_Busy), 32'd0);
        check_eq({tag, "_overrun"}, 32'(o_Overrun), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SB-1:0] s;
        model_reset();
        for (int a = 0; a < 256; a++) rom_tbl[a] = '0;
        repeat (3) @(negedge i_Clk);
        i_Reset = 1'b0;
        check_all_zero("reset");

        // all voices disabled still produces a valid zero sample
        plain_frame(s);
        check_eq("all_off", 32'(s), 32'd0);

        // voice 0 stepping through ROM addresses 0,1,2
        for (int a = 0; a < 256; a++) rom_tbl[a] = SB'(a << 8);
        cfg_write(0, 24'h010000, 1);
        plain_frame(s); check_eq("t1_f0", 32'(s), 32'h0000);
        plain_frame(s); check_eq("t1_f1", 32'(s), 32'h0040);
        plain_frame(s); check_eq("t1_f2", 32'(s), 32'h0080);

        // full-scale sums through the arithmetic shift
        for (int v = 0; v < N; v++) cfg_write(v, '0, 0);
        plain_frame(s);
        for (int a = 0; a < 256; a++) rom_tbl[a] = (a < 2) ? 16'h7FFF : 16'h8000;
        for (int v = 0; v < N; v++) cfg_write(v, AW'(v << 16), 1);
        plain_frame(s); check_eq("t2_max", 32'(s), 32'h7FFF);
        plain_frame(s); check_eq("t2_mixed", 32'(s), 32'hFFFF);
        for (int a = 0; a < 256; a++) rom_tbl[a] = 16'h8000;
        plain_frame(s); check_eq("t2_min", 32'(s), 32'h8000);

        // disable voice 0 mid-frame, then re-enable
        for (int a = 0; a < 256; a++) rom_tbl[a] = SB'($urandom);
        cfg_write(0, 24'h030000, 1);
        plain_frame(s);
        frame(0, 2, 0, 24'h030000, 0, s);
        plain_frame(s);
        cfg_write(0, 24'h050000, 1);
        plain_frame(s);
        plain_frame(s);

        // randomized frames with writes between, during, and coincident with ticks
        for (int f = 0; f < 40; f++) begin
            int nw, wk;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(0, N - 1), AW'($urandom), 1'($urandom_range(0, 3) != 0));
            repeat ($urandom_range(0, 2)) @(negedge i_Clk);
            wk = $urandom_range(0, 9);
            if (wk > 6) wk = -1;
            frame(0, wk, $urandom_range(0, N - 1), AW'($urandom), 1'($urandom_range(0, 1)), s);
        end

        // tick while busy: dropped, overrun sticky across frames
        frame(1, -1, 0, '0, 0, s);
        plain_frame(s);
        plain_frame(s);

        // reset in the middle of a frame
        i_Sample_Tick = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Sample_Tick = 1'b0;
        @(negedge i_Clk);
        i_Reset = 1'b1;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        model_reset();
        check_all_zero("midreset");
        for (int k = 0; k < 6; k++) begin
            @(negedge i_Clk);
            check_eq("post_reset_valid", 32'(o_Sample_Valid), 32'd0);
            check_eq("post_reset_busy", 32'(o_Busy), 32'd0);
        end
        for (int a = 0; a < 256; a++) rom_tbl[a] = SB'(a << 8);
        cfg_write(0, 24'h010000, 1);
        cfg_write(1, 24'h020000, 1);
        plain_frame(s); check_eq("reset_f0", 32'(s), 32'h0000);
        plain_frame(s); check_eq("reset_f1", 32'(s), 32'h00C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
